// File: rtl/frog_game_state.sv
// Frog game rule stage: per-frame collision/goal evaluation, lives and score
// bookkeeping, and the PLAY/HIT/WIN/OVER sequencer feeding the renderer.
module frog_game_state #(
  parameter int PLAYER_WIDTH  = 20,
  parameter int PLAYER_HEIGHT = 20,
  parameter int CAR_WIDTH     = 40,
  parameter int CAR_HEIGHT    = 20,
  parameter int GOAL_Y        = 64,
  parameter int LIVES_INIT    = 3,
  parameter int HIT_FRAMES    = 60,
  parameter int WIN_FRAMES    = 30
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [39:0] car_x,
  input  logic [39:0] car_y,
  output logic [1:0]  state,
  output logic [1:0]  lives,
  output logic [7:0]  score,
  output logic        respawn,
  output logic        flash,
  output logic        game_over
);

  localparam logic [1:0] S_PLAY = 2'd0;
  localparam logic [1:0] S_HIT  = 2'd1;
  localparam logic [1:0] S_WIN  = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam logic [10:0] PW = 11'(PLAYER_WIDTH);
  localparam logic [10:0] PH = 11'(PLAYER_HEIGHT);
  localparam logic [10:0] CW = 11'(CAR_WIDTH);
  localparam logic [10:0] CH = 11'(CAR_HEIGHT);
  localparam logic [9:0]  GOAL_ROW  = 10'(GOAL_Y);
  localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);
  localparam logic [7:0]  HIT_LAST  = 8'(HIT_FRAMES - 1);
  localparam logic [7:0]  WIN_LAST  = 8'(WIN_FRAMES - 1);

  logic [7:0]  counter;
  logic        start_d;
  logic [3:0]  car_hit;
  logic        hit;
  logic        goal;
  logic [10:0] px;
  logic [10:0] py;

  // Widen to 11 bits so box edges near 1023 do not wrap around.
  assign px = {1'b0, player_x};
  assign py = {1'b0, player_y};

  for (genvar n = 0; n < 4; n++) begin : g_car
    logic [10:0] cx;
    logic [10:0] cy;
    assign cx = {1'b0, car_x[10*n +: 10]};
    assign cy = {1'b0, car_y[10*n +: 10]};
    assign car_hit[n] = (px < cx + CW) && (cx < px + PW) &&
                        (py < cy + CH) && (cy < py + PH);
  end

  assign hit  = |car_hit;
  assign goal = (player_y <= GOAL_ROW);

  // respawn is gated by its own current value so it can never stay high
  // for two cycles, even with back-to-back frame_tick or start edges.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_PLAY;
      lives     <= LIVES_RST;
      score     <= 8'd0;
      respawn   <= 1'b0;
      flash     <= 1'b0;
      game_over <= 1'b0;
      counter   <= 8'd0;
      start_d   <= 1'b0;
    end else begin
      start_d <= start;
      respawn <= 1'b0;
      case (state)
        S_PLAY: begin
          if (frame_tick) begin
            if (hit) begin
              if (lives <= 2'd1) begin
                state     <= S_OVER;
                lives     <= 2'd0;
                game_over <= 1'b1;
                flash     <= 1'b0;
              end else begin
                state   <= S_HIT;
                lives   <= lives - 2'd1;
                counter <= 8'd0;
                flash   <= 1'b1;
              end
            end else if (goal) begin
              if (score != 8'hff) score <= score + 8'd1;
              respawn <= ~respawn;
              state   <= S_WIN;
              counter <= 8'd0;
            end
          end
        end
        S_HIT: begin
          if (frame_tick) begin
            if (counter == HIT_LAST) begin
              respawn <= ~respawn;
              flash   <= 1'b0;
              state   <= S_PLAY;
            end else begin
              counter <= counter + 8'd1;
              if (counter[2:0] == 3'd7) flash <= ~flash;
            end
          end
        end
        S_WIN: begin
          if (frame_tick) begin
            if (counter == WIN_LAST) state <= S_PLAY;
            else counter <= counter + 8'd1;
          end
        end
        default: begin
          flash <= 1'b0;
          if (start && !start_d) begin
            lives     <= LIVES_RST;
            score     <= 8'd0;
            respawn   <= ~respawn;
            game_over <= 1'b0;
            state     <= S_PLAY;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/frog_game_state.md
Name: frog_game_state

Overview:
- Game-rule stage directly upstream of the VGA pixel renderer in the Frog game.
- Once per video frame it compares the player box against the four car boxes and checks whether the player has reached the goal row.
- It tracks lives and score, sequences the PLAY/HIT/WIN/OVER game states, and drives respawn and flash controls consumed by player_control and the renderer.

Parameters:
PLAYER_WIDTH, 20, player box width in pixels
PLAYER_HEIGHT, 20, player box height in pixels
CAR_WIDTH, 40, car box width in pixels
CAR_HEIGHT, 20, car box height in pixels
GOAL_Y, 64, player_y at or below this value counts as a crossing
LIVES_INIT, 3, lives loaded at reset and restart (1..3)
HIT_FRAMES, 60, frames spent in HIT after a collision (>=1)
WIN_FRAMES, 30, frames spent in WIN after a crossing (>=1)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame, at start of vertical blank
start  in  1  restart request, level, already synchronised to CLK
player_x  in  10  player left edge
player_y  in  10  player top edge
car_x  in  40  four car left edges, car n in bits [10n+9:10n]
car_y  in  40  four car top edges, same packing
state  out  2  game state: 0 PLAY, 1 HIT, 2 WIN, 3 OVER
lives  out  2  remaining lives
score  out  8  completed crossings, saturating
respawn  out  1  one-cycle pulse telling player_control to return the frog to its start position
flash  out  1  renderer blanks the player while high
game_over  out  1  high while state is OVER

Behaviour:
- Reset: one clock, CLK. Reset is asynchronous and active-low on RST_N. Reset values: state=PLAY, lives=LIVES_INIT, score=0, respawn=0, flash=0, game_over=0, frame counter=0, start_d=0.
- All outputs are registered. Inputs are sampled only on the CLK edge where frame_tick=1, except start. Outputs change on that same edge, so results are visible one cycle after the tick cycle.
- Overlap test for car n: px < cx+CAR_WIDTH and cx < px+PLAYER_WIDTH and py < cy+CAR_HEIGHT and cy < py+PLAYER_HEIGHT.
  - All sums are computed at 11 bits, so there is no 10-bit wrap.
  - Comparisons are strict, so boxes that only touch at an edge do not collide.
- hit = OR of the four car overlaps. goal = (player_y <= GOAL_Y).
- PLAY, on frame_tick:
  - hit: lives <= lives-1.
    - If lives was 1: go to OVER, lives=0.
    - Otherwise: go to HIT, counter=0, flash=1.
  - else goal: score <= min(score+1, 255), respawn=1 for one cycle, go to WIN, counter=0.
  - If hit and goal occur on the same tick, hit takes priority and score is unchanged.
- HIT, on each frame_tick:
  - counter increments.
  - flash toggles whenever counter[2:0] wraps to 0, i.e. every 8 frames.
  - When counter reaches HIT_FRAMES-1: respawn=1 for one cycle, flash=0, go to PLAY.
  - No collision or goal checks are made in this state.
- WIN, on each frame_tick:
  - counter increments.
  - When counter reaches WIN_FRAMES-1: go to PLAY.
  - No checks are made in this state.
- OVER:
  - game_over=1, flash=0.
  - A rising edge of start is detected against registered start_d, sampled every cycle rather than only on frame_tick. On that edge: lives=LIVES_INIT, score=0, respawn=1 for one cycle, go to PLAY.
  - A start edge in any other state is ignored.
- respawn:
  - Never high for two consecutive cycles.
  - Never asserted in the same cycle as entry to OVER.
- frame_tick high for more than one cycle: each high cycle counts as a frame. This is legal but not expected.
- Reset asserted mid-HIT or mid-WIN: all outputs return to their reset values immediately, asynchronously.
- The counter is 8 bits wide. HIT_FRAMES and WIN_FRAMES must be <= 256.

Test Plan:
1. Reset release, player (300,460), cars far away, 5 ticks -> state=0, lives=3, score=0, respawn never high.
2. Player (210,320), car0 at (200,320), one tick -> next cycle state=1, lives=2, flash=1. After 60 more ticks: one respawn pulse, state=0, flash=0. flash toggles at frames 8, 16, ...
3. Player (240,320), car0 at (200,320), one tick (edge touch, 200+40=240) -> no hit, state=0, lives=3.
4. Player y=64, no cars overlapping, one tick -> score=1, respawn pulse, state=2. After 30 ticks: state=0. Repeat 300 crossings -> score holds at 255.
5. Player overlapping car2 and y=50 on the same tick -> state=1, lives=2, score unchanged.
6. Three hits in succession -> lives 2, 1, then state=3, lives=0, game_over=1. Hold start=1 for 3 cycles -> exactly one respawn pulse, lives=3, score=0, state=0. Assert RST_N=0 mid-HIT -> outputs return to reset values without waiting for a clock edge.
